// File: rtl/pulse_ctrl_pkg.sv
// Shared definitions for the pulse parameter controller: opcodes, FSM states,
// the parameter bank layout and its power-on contents.
package pulse_ctrl_pkg;

  localparam logic [7:0] OP_PERIOD   = 8'h01;
  localparam logic [7:0] OP_P1WIDTH  = 8'h02;
  localparam logic [7:0] OP_P2WIDTH  = 8'h03;
  localparam logic [7:0] OP_DELAY    = 8'h04;
  localparam logic [7:0] OP_OFFRES   = 8'h05;
  localparam logic [7:0] OP_FLAGS    = 8'h06;
  localparam logic [7:0] OP_ATT      = 8'h07;
  localparam logic [7:0] OP_APPLY    = 8'h10;
  localparam logic [7:0] OP_RUN      = 8'h11;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 1200000;
  localparam int unsigned DEF_ATT_DELAY      = 2000;
  localparam int unsigned DEF_ST_PERIOD      = 20000;
  localparam int unsigned DEF_ST_P1WIDTH     = 30;
  localparam int unsigned DEF_ST_P2WIDTH     = 30;
  localparam int unsigned DEF_ST_DELAY       = 200;
  localparam int unsigned DEF_ST_PULSE_BLOCK = 50;
  localparam int unsigned OFFRES_BACKOFF     = 8000;

  localparam int unsigned DEF_P2START  = DEF_ST_P1WIDTH + DEF_ST_DELAY;
  localparam int unsigned DEF_SYNC_UP  = DEF_P2START + DEF_ST_P2WIDTH;
  localparam int unsigned DEF_ATT_DOWN = DEF_SYNC_UP + DEF_ATT_DELAY;
  localparam int unsigned DEF_OFFRES   = DEF_ST_PERIOD - OFFRES_BACKOFF + DEF_ST_P1WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_DATA, S_WRITE, S_CALC_A, S_CALC_B, S_CALC_C, S_WAIT_BOUND, S_COMMIT
  } state_t;

  typedef struct packed {
    logic [31:0] period;
    logic [31:0] p1width;
    logic [31:0] p2width;
    logic [31:0] delay;
    logic [31:0] p2start;
    logic [31:0] sync_up;
    logic [31:0] att_down;
    logic [31:0] offres_delay;
    logic        pump;
    logic        double;
    logic        resetn;
    logic [7:0]  pulse_block;
    logic [6:0]  pp_pump;
    logic [6:0]  pp_probe;
    logic [6:0]  post_att;
  } param_bank_t;

  // Power-on bank with the derived edge times already consistent.
  function automatic param_bank_t reset_bank(input int unsigned per, p1, p2, dly, pb, att_delay);
    param_bank_t b;
    b.period       = per;
    b.p1width      = p1;
    b.p2width      = p2;
    b.delay        = dly;
    b.p2start      = p1 + dly;
    b.sync_up      = p1 + dly + p2;
    b.att_down     = p1 + dly + p2 + att_delay;
    b.offres_delay = per - OFFRES_BACKOFF + p1;
    b.pump         = 1'b1;
    b.double       = 1'b1;
    b.resetn       = 1'b0;
    b.pulse_block  = pb[7:0];
    b.pp_pump      = 7'h00;
    b.pp_probe     = 7'h7F;
    b.post_att     = 7'h7F;
    return b;
  endfunction

endpackage

// File: rtl/pulse_cmd_deframer.sv
// Assembles opcode + 4 MSB-first data bytes into a frame and drops a frame
// whose bytes stop arriving for TIMEOUT_CYCLES cycles.
module pulse_cmd_deframer
  import pulse_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_ready,
  output logic        frame_valid,
  output logic [7:0]  opcode,
  output logic [31:0] d,
  output logic        frame_timeout
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]    byte_cnt;
  logic [TW-1:0] idle_cnt;
  logic          accept;
  logic          in_frame;

  assign accept   = rx_valid && rx_ready;
  assign in_frame = (byte_cnt != 3'd0);

  // NOTE: frame_valid and frame_timeout are combinational so the controller
  // can change state on the very edge that takes the last byte or idle cycle.
  assign frame_valid   = accept && (byte_cnt == 3'd4);
  assign frame_timeout = in_frame && !rx_valid && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt <= 3'd0;
      idle_cnt <= '0;
      opcode   <= 8'h00;
      d        <= 32'h0;
    end else if (accept) begin
      idle_cnt <= '0;
      if (!in_frame) begin
        opcode   <= rx_data;
        byte_cnt <= 3'd1;
      end else begin
        d        <= {d[23:0], rx_data};
        byte_cnt <= frame_valid ? 3'd0 : byte_cnt + 3'd1;
      end
    end else if (frame_timeout) begin
      byte_cnt <= 3'd0;
      idle_cnt <= '0;
    end else if (in_frame && !rx_valid) begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end

endmodule

// File: rtl/pulse_param_ctrl.sv
// Stages parameter writes from UART frames in a shadow bank, validates the
// derived edge times, and commits the whole bank atomically on a period wrap.
module pulse_param_ctrl
  import pulse_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned ATT_DELAY      = DEF_ATT_DELAY,
  parameter int unsigned ST_PERIOD      = DEF_ST_PERIOD,
  parameter int unsigned ST_P1WIDTH     = DEF_ST_P1WIDTH,
  parameter int unsigned ST_P2WIDTH     = DEF_ST_P2WIDTH,
  parameter int unsigned ST_DELAY       = DEF_ST_DELAY,
  parameter int unsigned ST_PULSE_BLOCK = DEF_ST_PULSE_BLOCK
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        period_start,
  output logic [31:0] period,
  output logic [31:0] p1width,
  output logic [31:0] p2width,
  output logic [31:0] delay,
  output logic [31:0] p2start,
  output logic [31:0] sync_up,
  output logic [31:0] att_down,
  output logic [31:0] offres_delay,
  output logic        pump,
  output logic        double,
  output logic        resetn,
  output logic [7:0]  pulse_block,
  output logic [6:0]  pp_pump,
  output logic [6:0]  pp_probe,
  output logic [6:0]  post_att,
  output logic        busy,
  output logic        cmd_ack,
  output logic        cmd_err
);

  localparam param_bank_t RESET_BANK =
    reset_bank(ST_PERIOD, ST_P1WIDTH, ST_P2WIDTH, ST_DELAY, ST_PULSE_BLOCK, ATT_DELAY);

  state_t      state;
  param_bank_t shadow;
  param_bank_t active;
  logic        carry;
  logic        frame_valid;
  logic        frame_timeout;
  logic [7:0]  opcode;
  logic [31:0] d;
  logic [32:0] sum_a;
  logic [32:0] sum_b;
  logic [32:0] sum_c;

  pulse_cmd_deframer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_deframer (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .frame_valid  (frame_valid),
    .opcode       (opcode),
    .d            (d),
    .frame_timeout(frame_timeout)
  );

  assign rx_ready = (state == S_IDLE) || (state == S_DATA);
  assign busy     = (state != S_IDLE);

  // 33-bit sums expose the carry out of each 32-bit add.
  assign sum_a = {1'b0, shadow.p1width} + {1'b0, shadow.delay};
  assign sum_b = {1'b0, shadow.p2start} + {1'b0, shadow.p2width};
  assign sum_c = {1'b0, shadow.sync_up} + 33'(ATT_DELAY);

  assign period       = active.period;
  assign p1width      = active.p1width;
  assign p2width      = active.p2width;
  assign delay        = active.delay;
  assign p2start      = active.p2start;
  assign sync_up      = active.sync_up;
  assign att_down     = active.att_down;
  assign offres_delay = active.offres_delay;
  assign pump         = active.pump;
  assign double       = active.double;
  assign resetn       = active.resetn;
  assign pulse_block  = active.pulse_block;
  assign pp_pump      = active.pp_pump;
  assign pp_probe     = active.pp_probe;
  assign post_att     = active.post_att;

  // NOTE: both banks are plain flops with defined reset values; reset must
  // restore the power-on parameters, so they cannot be left uninitialised.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      shadow  <= RESET_BANK;
      active  <= RESET_BANK;
      carry   <= 1'b0;
      cmd_ack <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      cmd_ack <= 1'b0;
      cmd_err <= 1'b0;
      case (state)
        S_IDLE: if (rx_valid) state <= S_DATA;
        S_DATA: begin
          if (frame_valid) begin
            state <= S_WRITE;
          end else if (frame_timeout) begin
            cmd_err <= 1'b1;
            state   <= S_IDLE;
          end
        end
        S_WRITE: begin
          state <= S_IDLE;
          case (opcode)
            OP_PERIOD:  shadow.period       <= d;
            OP_P1WIDTH: shadow.p1width      <= d;
            OP_P2WIDTH: shadow.p2width      <= d;
            OP_DELAY:   shadow.delay        <= d;
            OP_OFFRES:  shadow.offres_delay <= d;
            OP_FLAGS: begin
              shadow.pump        <= d[0];
              shadow.double      <= d[1];
              shadow.pulse_block <= d[15:8];
            end
            OP_ATT: begin
              shadow.pp_pump  <= d[6:0];
              shadow.pp_probe <= d[14:8];
              shadow.post_att <= d[22:16];
            end
            OP_RUN:   shadow.resetn <= d[0];
            OP_APPLY: state <= S_CALC_A;
            default:  cmd_err <= 1'b1;
          endcase
        end
        S_CALC_A: begin
          shadow.p2start <= sum_a[31:0];
          carry          <= sum_a[32];
          state          <= S_CALC_B;
        end
        S_CALC_B: begin
          shadow.sync_up <= sum_b[31:0];
          carry          <= carry | sum_b[32];
          state          <= S_CALC_C;
        end
        S_CALC_C: begin
          shadow.att_down <= sum_c[31:0];
          if (carry || sum_c[32] || (sum_c[31:0] >= shadow.period)) begin
            cmd_err <= 1'b1;
            state   <= S_IDLE;
          end else begin
            state <= S_WAIT_BOUND;
          end
        end
        // A stopped generator has no period boundary to wait for.
        S_WAIT_BOUND: begin
          if (!active.resetn || period_start) begin
            active  <= shadow;
            cmd_ack <= 1'b1;
            state   <= S_COMMIT;
          end
        end
        S_COMMIT: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_param_ctrl.sv
// Scoreboard bench: every expected cmd_ack/cmd_err response is queued when the
// frame is sent and compared against the active outputs when it appears.
module tb_pulse_param_ctrl;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        period_start;
  logic [31:0] period, p1width, p2width, delay, p2start, sync_up, att_down, offres_delay;
  logic        pump, dbl, resetn;
  logic [7:0]  pulse_block;
  logic [6:0]  pp_pump, pp_probe, post_att;
  logic        busy, cmd_ack, cmd_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          ack;
    logic [31:0] period;
    logic [31:0] delay;
    logic [31:0] p2width;
    logic [31:0] p2start;
    logic [31:0] sync_up;
    logic [31:0] att_down;
    logic        resetn;
  } exp_t;

  exp_t exp_q[$];

  pulse_param_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .period_start(period_start), .period(period), .p1width(p1width), .p2width(p2width),
    .delay(delay), .p2start(p2start), .sync_up(sync_up), .att_down(att_down),
    .offres_delay(offres_delay), .pump(pump), .double(dbl), .resetn(resetn),
    .pulse_block(pulse_block), .pp_pump(pp_pump), .pp_probe(pp_probe), .post_att(post_att),
    .busy(busy), .cmd_ack(cmd_ack), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic push_exp(input bit ack, input logic [31:0] per, dly, p2w, p2s, syn, att,
                          input logic rn);
    exp_t e;
    e.ack = ack; e.period = per; e.delay = dly; e.p2width = p2w;
    e.p2start = p2s; e.sync_up = syn; e.att_down = att; e.resetn = rn;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; period_start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      checks++; errors++;
      $display("FAIL rx_ready_wait: rx_ready=%0b required 1 within 100 cycles", rx_ready);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] data);
    send_byte(op);
    for (int i = 3; i >= 0; i--) send_byte(data[8*i +: 8]);
  endtask

  task automatic wait_resp(input int max_cycles);
    int n = 0;
    @(negedge clk);
    while (!(cmd_ack || cmd_err) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (!(cmd_ack || cmd_err)) begin
      checks++; errors++;
      $display("FAIL resp_wait: no cmd_ack/cmd_err within %0d cycles", max_cycles);
    end
  endtask

  // Consumes one queued expectation at a cycle where the DUT is responding.
  task automatic scoreboard_pop(input string tag);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_queue: response with empty scoreboard (ack=%0b err=%0b)", tag, cmd_ack, cmd_err);
      return;
    end
    e = exp_q.pop_front();
    checks += 8;
    if (cmd_ack !== e.ack)   begin errors++; $display("FAIL %s_ack: got %0b want %0b", tag, cmd_ack, e.ack); end
    if (cmd_err !== !e.ack)  begin errors++; $display("FAIL %s_err: got %0b want %0b", tag, cmd_err, !e.ack); end
    if (period !== e.period) begin errors++; $display("FAIL %s_period: got %0d want %0d", tag, period, e.period); end
    if (delay !== e.delay)   begin errors++; $display("FAIL %s_delay: got %0d want %0d", tag, delay, e.delay); end
    if (p2width !== e.p2width) begin errors++; $display("FAIL %s_p2width: got %0d want %0d", tag, p2width, e.p2width); end
    if (p2start !== e.p2start) begin errors++; $display("FAIL %s_p2start: got %0d want %0d", tag, p2start, e.p2start); end
    if ({sync_up, att_down} !== {e.sync_up, e.att_down}) begin
      errors++; $display("FAIL %s_sync_att: got %0d/%0d want %0d/%0d", tag, sync_up, att_down, e.sync_up, e.att_down);
    end
    if (resetn !== e.resetn) begin errors++; $display("FAIL %s_resetn: got %0b want %0b", tag, resetn, e.resetn); end
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; period_start = 1'b0;
    repeat (2) @(negedge clk);
    checks += 8;
    if ({period, p1width, p2width, delay} !== {32'd20000, 32'd30, 32'd30, 32'd200}) begin
      errors++; $display("FAIL reset_base: got %0d %0d %0d %0d want 20000 30 30 200", period, p1width, p2width, delay);
    end
    if ({p2start, sync_up, att_down} !== {32'd230, 32'd260, 32'd2260}) begin
      errors++; $display("FAIL reset_derived: got %0d %0d %0d want 230 260 2260", p2start, sync_up, att_down);
    end
    if (offres_delay !== 32'd12030) begin errors++; $display("FAIL reset_offres: got %0d want 12030", offres_delay); end
    if ({pump, dbl, resetn} !== 3'b110) begin errors++; $display("FAIL reset_flags: got %b want 110", {pump, dbl, resetn}); end
    if (pulse_block !== 8'd50) begin errors++; $display("FAIL reset_pulse_block: got %0d want 50", pulse_block); end
    if ({pp_pump, pp_probe, post_att} !== {7'h00, 7'h7F, 7'h7F}) begin
      errors++; $display("FAIL reset_att: got %h %h %h want 00 7f 7f", pp_pump, pp_probe, post_att);
    end
    if ({busy, cmd_ack, cmd_err} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b want 000", {busy, cmd_ack, cmd_err}); end
    if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready: got %0b want 1", rx_ready); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_apply_stopped();
    do_reset();
    send_frame(8'h01, 32'h0000_9C40);
    push_exp(1'b1, 32'd40000, 32'd200, 32'd30, 32'd230, 32'd260, 32'd2260, 1'b0);
    send_frame(8'h10, 32'h0);
    @(negedge clk);
    checks++;
    if ({rx_ready, busy} !== 2'b01) begin errors++; $display("FAIL stopped_write_ready: got %b want 01", {rx_ready, busy}); end
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({period, cmd_ack} !== {32'd20000, 1'b0}) begin
      errors++; $display("FAIL stopped_early: period=%0d ack=%0b want 20000/0 four edges after last byte", period, cmd_ack);
    end
    @(negedge clk);
    scoreboard_pop("stopped");
    @(negedge clk);
    checks++;
    if ({cmd_ack, busy} !== 2'b00) begin errors++; $display("FAIL stopped_ack_pulse: ack/busy=%b want 00", {cmd_ack, busy}); end
  endtask

  task automatic test_apply_running();
    bit seen = 1'b0;
    do_reset();
    send_frame(8'h11, 32'h0000_0001);
    push_exp(1'b1, 32'd20000, 32'd200, 32'd30, 32'd230, 32'd260, 32'd2260, 1'b1);
    send_frame(8'h10, 32'h0);
    wait_resp(20);
    scoreboard_pop("run_on");
    send_frame(8'h04, 32'h0000_01F4);
    push_exp(1'b1, 32'd20000, 32'd500, 32'd30, 32'd530, 32'd560, 32'd2560, 1'b1);
    send_frame(8'h10, 32'h0);
    period_start = 1'b1;
    @(posedge clk);
    #1 period_start = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (cmd_ack) seen = 1'b1;
    end
    checks++;
    if ({seen, busy, delay, att_down} !== {1'b0, 1'b1, 32'd200, 32'd2260}) begin
      errors++; $display("FAIL running_hold: ack_seen=%0b busy=%0b delay=%0d att=%0d want 0 1 200 2260", seen, busy, delay, att_down);
    end
    period_start = 1'b1;
    @(posedge clk);
    #1 period_start = 1'b0;
    @(negedge clk);
    scoreboard_pop("running");
  endtask

  task automatic test_reject_period();
    bit seen = 1'b0;
    do_reset();
    send_frame(8'h01, 32'h0000_03E8);
    push_exp(1'b0, 32'd20000, 32'd200, 32'd30, 32'd230, 32'd260, 32'd2260, 1'b0);
    send_frame(8'h10, 32'h0);
    wait_resp(20);
    scoreboard_pop("reject");
    repeat (20) begin
      @(negedge clk);
      if (cmd_ack) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL reject_no_ack: ack_seen=%0b want 0", seen); end
  endtask

  task automatic test_carry();
    do_reset();
    send_frame(8'h02, 32'hFFFF_FFFF);
    push_exp(1'b0, 32'd20000, 32'd200, 32'd30, 32'd230, 32'd260, 32'd2260, 1'b0);
    send_frame(8'h10, 32'h0);
    wait_resp(20);
    scoreboard_pop("carry");
    checks++;
    if (p1width !== 32'd30) begin errors++; $display("FAIL carry_p1width: got %0d want 30", p1width); end
  endtask

  task automatic test_bad_opcode();
    do_reset();
    push_exp(1'b0, 32'd20000, 32'd200, 32'd30, 32'd230, 32'd260, 32'd2260, 1'b0);
    send_frame(8'h55, 32'h1234_5678);
    wait_resp(10);
    scoreboard_pop("bad_op");
  endtask

  task automatic test_flags_att();
    do_reset();
    send_frame(8'h05, 32'h0000_1000);
    send_frame(8'h06, 32'h0000_2A02);
    send_frame(8'h07, 32'h0055_3311);
    push_exp(1'b1, 32'd20000, 32'd200, 32'd30, 32'd230, 32'd260, 32'd2260, 1'b0);
    send_frame(8'h10, 32'h0);
    wait_resp(20);
    scoreboard_pop("flags");
    checks++;
    if ({offres_delay, pump, dbl, pulse_block, pp_pump, pp_probe, post_att} !==
        {32'h1000, 1'b0, 1'b1, 8'h2A, 7'h11, 7'h33, 7'h55}) begin
      errors++; $display("FAIL flags_fields: got %h %b%b %h %h %h %h want 1000 01 2a 11 33 55",
                         offres_delay, pump, dbl, pulse_block, pp_pump, pp_probe, post_att);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    push_exp(1'b0, 32'd20000, 32'd200, 32'd30, 32'd230, 32'd260, 32'd2260, 1'b0);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (TMO - 1) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cmd_err, busy} !== 2'b01) begin errors++; $display("FAIL timeout_early: err/busy=%b want 01", {cmd_err, busy}); end
    @(negedge clk);
    scoreboard_pop("timeout");
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: busy=%0b want 0", busy); end
    send_frame(8'h01, 32'h0000_9C40);
    push_exp(1'b1, 32'd40000, 32'd200, 32'd30, 32'd230, 32'd260, 32'd2260, 1'b0);
    send_frame(8'h10, 32'h0);
    wait_resp(20);
    scoreboard_pop("after_timeout");
  endtask

  task automatic test_reset_wait_bound();
    do_reset();
    send_frame(8'h11, 32'h0000_0001);
    push_exp(1'b1, 32'd20000, 32'd200, 32'd30, 32'd230, 32'd260, 32'd2260, 1'b1);
    send_frame(8'h10, 32'h0);
    wait_resp(20);
    scoreboard_pop("wb_run");
    send_frame(8'h03, 32'h0000_0064);
    send_frame(8'h10, 32'h0);
    repeat (10) @(negedge clk);
    checks++;
    if ({busy, p2width} !== {1'b1, 32'd30}) begin errors++; $display("FAIL wb_waiting: busy=%0b p2width=%0d want 1 30", busy, p2width); end
    reset = 1'b1;
    #1;
    checks++;
    if ({p2width, resetn, busy, period, att_down, cmd_ack} !== {32'd30, 1'b0, 1'b0, 32'd20000, 32'd2260, 1'b0}) begin
      errors++; $display("FAIL wb_async_reset: p2width=%0d resetn=%0b busy=%0b period=%0d att=%0d ack=%0b",
                         p2width, resetn, busy, period, att_down, cmd_ack);
    end
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    push_exp(1'b1, 32'd20000, 32'd200, 32'd30, 32'd230, 32'd260, 32'd2260, 1'b0);
    send_frame(8'h10, 32'h0);
    wait_resp(20);
    scoreboard_pop("wb_shadow_reset");
  endtask

  initial begin
    test_reset();
    test_apply_stopped();
    test_apply_running();
    test_reject_period();
    test_carry();
    test_bad_opcode();
    test_flags_att();
    test_timeout();
    test_reset_wait_bound();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d expected responses never seen, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
